load_store_unit: RTL and testbench

Byte-addressed load/store front end for the word-addressed 128x32 data memory. Converts execute-stage requests for LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses, and performs alignment checks and sign/zero extension. Sub-word stores use read-modify-write. The block sits directly upstream of the data memory and drives its mem_write/m_addr/m_w_data ports. It consumes m_r_data, which is registered in the memory on posedge (1-cycle read latency) and written on negedge.

---
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed DEPTH x 32 data memory.
// Turns LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. It checks alignment
// and range, sign- or zero-extends loads, and does read-modify-write for sub-word stores.
// The memory registers its read data on posedge and writes on negedge.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req / ready         request valid / unit idle (ready is decoded from state)
//   is_store, op        access kind, funct3 encoding (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr, wdata         byte address, store data
//   done, err, rdata    registered completion pulse, error flag, load result
//   mem_write, m_addr,  memory write enable, word index, write data
//   m_w_data, m_r_data  registered read data returned by the memory
module load_store_unit #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned IDX_W = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ready,
    input  logic        is_store,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_w_data,
    input  logic [31:0] m_r_data
);

    localparam int unsigned ADDR_LIMIT = 4 * DEPTH;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        DATA = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  op_q, op_nx;
    logic        is_store_q, is_store_nx;
    logic [1:0]  lane_q, lane_nx;
    logic [15:0] wdata_q, wdata_nx;
    logic        done_nx, err_nx, mem_write_nx;
    logic [31:0] rdata_nx, m_addr_nx, m_w_data_nx;

    logic misaligned_c, range_c, illegal_c, acc_err_c;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] o,
                                                 input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (o)
            OP_B:    return {{24{b[7]}}, b};
            OP_H:    return {{16{h[15]}}, h};
            OP_W:    return w;
            OP_BU:   return {24'd0, b};
            OP_HU:   return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    // Replace only the addressed byte/halfword lane of the old word.
    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [2:0] o,
                                                input logic [1:0] lane, input logic [15:0] d);
        logic [31:0] m;
        m = w;
        if (o == OP_H) m[{lane[1], 4'b0000} +: 16] = d;
        else           m[{lane, 3'b000} +: 8]      = d[7:0];
        return m;
    endfunction

    assign ready = (state == IDLE);

    // Request screening, evaluated against the live inputs on the accept edge.
    always_comb begin
        misaligned_c = ((op == OP_H || op == OP_HU) && addr[0]) ||
                       (op == OP_W && addr[1:0] != 2'b00);
        range_c      = (addr >= 32'(ADDR_LIMIT));
        if (is_store) illegal_c = !(op == OP_B || op == OP_H || op == OP_W);
        else          illegal_c = (op == 3'b011) || (op[2:1] == 2'b11);
        acc_err_c    = misaligned_c || range_c || illegal_c;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx     = state;
        op_nx        = op_q;
        is_store_nx  = is_store_q;
        lane_nx      = lane_q;
        wdata_nx     = wdata_q;
        err_nx       = err;
        rdata_nx     = rdata;
        m_addr_nx    = m_addr;
        m_w_data_nx  = m_w_data;

        case (state)
            IDLE: begin
                if (req) begin
                    op_nx       = op;
                    is_store_nx = is_store;
                    lane_nx     = addr[1:0];
                    wdata_nx    = wdata[15:0];
                    err_nx      = acc_err_c;
                    rdata_nx    = 32'd0;
                    if (acc_err_c) begin
                        state_nx = DONE;
                    end else begin
                        m_addr_nx = 32'(addr[IDX_W+1:2]);
                        if (is_store && op == OP_W) begin
                            m_w_data_nx = wdata;
                            state_nx    = WR;
                        end else begin
                            state_nx = RD;
                        end
                    end
                end
            end
            RD:   state_nx = DATA;
            DATA: begin
                if (is_store_q) begin
                    m_w_data_nx = store_merge(m_r_data, op_q, lane_q, wdata_q);
                    state_nx    = WR;
                end else begin
                    rdata_nx = load_extract(m_r_data, op_q, lane_q);
                    state_nx = DONE;
                end
            end
            WR:      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        done_nx      = (state_nx == DONE);
        mem_write_nx = (state_nx == WR);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            op_q       <= 3'd0;
            is_store_q <= 1'b0;
            lane_q     <= 2'd0;
            wdata_q    <= 16'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= 32'd0;
            mem_write  <= 1'b0;
            m_addr     <= 32'd0;
            m_w_data   <= 32'd0;
        end else begin
            state      <= state_nx;
            op_q       <= op_nx;
            is_store_q <= is_store_nx;
            lane_q     <= lane_nx;
            wdata_q    <= wdata_nx;
            done       <= done_nx;
            err        <= err_nx;
            rdata      <= rdata_nx;
            mem_write  <= mem_write_nx;
            m_addr     <= m_addr_nx;
            m_w_data   <= m_w_data_nx;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 128x32 data memory.
module tb_load_store_unit;

    localparam logic [2:0] OB  = 3'b000;
    localparam logic [2:0] OH  = 3'b001;
    localparam logic [2:0] OW  = 3'b010;
    localparam logic [2:0] OBU = 3'b100;
    localparam logic [2:0] OHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        ready;
    logic        is_store = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        done, err, mem_write;
    logic [31:0] rdata, m_addr, m_w_data;
    logic [31:0] m_r_data = 32'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int writes_seen = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          writes;
        logic [31:0] waddr;
        int          acc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [128];
    bit seeded = 1'b0;

    load_store_unit #(.DEPTH(128), .IDX_W(7)) dut (
        .clk(clk), .rst(rst), .req(req), .ready(ready), .is_store(is_store),
        .op(op), .addr(addr), .wdata(wdata), .done(done), .err(err), .rdata(rdata),
        .mem_write(mem_write), .m_addr(m_addr), .m_w_data(m_w_data), .m_r_data(m_r_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: registered read on posedge, write on negedge.
    always @(posedge clk) m_r_data <= mem[m_addr[6:0]];
    always @(negedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 128; i++) mem[i] = 32'd0;
            mem[4] = 32'hA5A5_A5A5;
            seeded = 1'b1;
        end else if (mem_write) begin
            mem[m_addr[6:0]] = m_w_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every write and every completion against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            writes_seen = 0;
        end else begin
            if (mem_write) begin
                writes_seen++;
                if (sb.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else                chk("write_addr", m_addr, sb[0].waddr);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("err", 32'(err), 32'(e.err));
                    chk("rdata", rdata, e.rdata);
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("write_count", 32'(writes_seen), 32'(e.writes));
                end
                writes_seen = 0;
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready) return;
        end
        chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic issue(input logic st, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                         input int e_lat, input int e_wr, input logic [31:0] e_wa,
                         input bit push);
        exp_t e;
        wait_ready();
        req = 1'b1; is_store = st; op = o; addr = a; wdata = wd;
        if (push) begin
            e.err = e_err; e.rdata = e_rd; e.lat = e_lat; e.writes = e_wr;
            e.waddr = e_wa; e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && ready) return;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held while req toggles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req = ~req;
            #1;
            chk("rst_ready", 32'(ready), 32'd1);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_mem_write", 32'(mem_write), 32'd0);
            chk("rst_m_addr", m_addr, 32'd0);
        end
        @(negedge clk);
        req = 1'b0;
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b1;

        // Loads / stores: st, op, addr, wdata, err, rdata, latency, writes, write index
        issue(0, OW, 32'h10, 0, 0, 32'hA5A5_A5A5, 3, 0, 0, 1);
        issue(1, OW, 32'h08, 32'hDEAD_BEEF, 0, 0, 2, 1, 2, 1);
        issue(0, OW, 32'h08, 0, 0, 32'hDEAD_BEEF, 3, 0, 0, 1);
        issue(1, OB, 32'h09, 32'h0000_0055, 0, 0, 4, 1, 2, 1);
        issue(0, OW, 32'h08, 0, 0, 32'hDEAD_55EF, 3, 0, 0, 1);
        issue(0, OB, 32'h0B, 0, 0, 32'hFFFF_FFDE, 3, 0, 0, 1);
        issue(0, OBU, 32'h0B, 0, 0, 32'h0000_00DE, 3, 0, 0, 1);
        issue(0, OHU, 32'h0A, 0, 0, 32'h0000_DEAD, 3, 0, 0, 1);
        issue(0, OH, 32'h0A, 0, 0, 32'hFFFF_DEAD, 3, 0, 0, 1);
        issue(0, OB, 32'h08, 0, 0, 32'hFFFF_FFEF, 3, 0, 0, 1);
        issue(0, OH, 32'h08, 0, 0, 32'h0000_55EF, 3, 0, 0, 1);
        issue(1, OH, 32'h0E, 32'hFFFF_1234, 0, 0, 4, 1, 3, 1);
        issue(0, OW, 32'h0C, 0, 0, 32'h1234_0000, 3, 0, 0, 1);
        issue(0, OW, 32'h1FC, 0, 0, 32'h0, 3, 0, 0, 1);
        issue(0, OHU, 32'h1FE, 0, 0, 32'h0, 3, 0, 0, 1);
        drain();
        chk("mem_word3", mem[3], 32'h1234_0000);

        // Error cases: 1-cycle completion, no write, rdata cleared.
        issue(0, OW, 32'h06, 0, 1, 0, 1, 0, 0, 1);
        issue(1, OH, 32'h03, 32'hFFFF, 1, 0, 1, 0, 0, 1);
        issue(0, OB, 32'h200, 0, 1, 0, 1, 0, 0, 1);
        issue(0, 3'b011, 32'h00, 0, 1, 0, 1, 0, 0, 1);
        issue(1, OBU, 32'h08, 32'h11, 1, 0, 1, 0, 0, 1);
        issue(0, 3'b110, 32'h08, 0, 1, 0, 1, 0, 0, 1);
        issue(1, OW, 32'h200, 32'h1, 1, 0, 1, 0, 0, 1);
        drain();
        chk("mem_word2_after_err", mem[2], 32'hDEAD_55EF);
        chk("mem_word0_after_err", mem[0], 32'h0);

        // Reset asserted while an SB sits in WR: write dropped, no done.
        issue(1, OB, 32'h10, 32'h77, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if (mem_write) break;
            @(posedge clk);
            #1;
        end
        chk("abort_reached_wr", 32'(mem_write), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_mem_word4", mem[4], 32'hA5A5_A5A5);

        // Request while busy is ignored.
        issue(0, OW, 32'h08, 0, 0, 32'hDEAD_55EF, 3, 0, 0, 1);
        req = 1'b1; is_store = 1'b1; op = OW; addr = 32'h08; wdata = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1 req = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        chk("busy_req_mem_word2", mem[2], 32'hDEAD_55EF);

        // Unit still works after the abort.
        issue(0, OB, 32'h13, 0, 0, 32'hFFFF_FFA5, 3, 0, 0, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
